ip_codma_bus_responder: RTL and testbench
=========================================

Name: ip_codma_bus_responder

Overview:
- Memory-side responder for the codma read and write request/grant protocol.
- Answers the DMA's read-channel requests (RD_IDLE→RD_ASK→RD_GRANTED) and write-channel requests (WR_IDLE→WR_ASK→WR_GRANTED) from an internal word memory.
- Grant latency is programmable and range/alignment checking returns an error.
- Used as the slave in system integration and as the standard responder in codma benches.

Parameters:
- DEPTH, 1024: number of 32-bit words in the backing memory.
- LATENCY, 2: idle cycles inserted between accepting a request and granting it (0..15).
- ADDR_W, 32: byte-address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- rd_req_i  in  1  read request; held high until rd_done_o or rd_err_o.
- rd_addr_i  in  ADDR_W  read start byte address.
- rd_size_i  in  4  read beats minus one (1..16 beats).
- rd_gnt_o  out  1  read granted; high for the whole data phase.
- rd_valid_o  out  1  read beat valid.
- rd_data_o  out  32  read beat data.
- rd_done_o  out  1  read burst complete.
- rd_err_o  out  1  read rejected.
- wr_req_i  in  1  write request; same hold rule as read.
- wr_addr_i  in  ADDR_W  write start byte address.
- wr_size_i  in  4  write beats minus one.
- wr_valid_i  in  1  write beat present.
- wr_data_i  in  32  write beat data.
- wr_gnt_o  out  1  write granted.
- wr_ready_o  out  1  write beat accepted when wr_valid_i is also high.
- wr_done_o  out  1  write burst complete.
- wr_err_o  out  1  write rejected.

Behaviour:
- Reset (reset_i high at a clk_i edge): FSM to RSP_IDLE; every output 0; beat and latency counters 0. Memory contents are not reset. Reset mid-burst abandons the burst; beats already written stay written.
- One transaction at a time. Only outputs of the active channel may assert; the other channel's outputs stay 0.
- RSP_IDLE:
  - wr_req_i high: latch wr_addr_i and wr_size_i, channel=WR, go to RSP_WAIT. Write wins when both requests are high.
  - Otherwise rd_req_i high: latch rd_addr_i and rd_size_i, channel=RD, go to RSP_WAIT.
  - Latency counter loads LATENCY on entry to RSP_WAIT.
- RSP_WAIT:
  - Counter nonzero: decrement.
  - Counter zero, request invalid: go to RSP_ERROR. Invalid means addr[1:0]≠0, or addr/4 + size + 1 > DEPTH. Compute the bound at ADDR_W+1 bits so it cannot wrap.
  - Counter zero, request valid: go to RSP_GRANTED.
  - gnt rises exactly LATENCY+2 cycles after the request edge sampled in RSP_IDLE.
- RSP_GRANTED, read channel:
  - rd_gnt_o=1 and rd_valid_o=1 every cycle.
  - rd_data_o = mem[addr/4 + beat], registered. The first beat coincides with rd_gnt_o rising, so prefetch on the RSP_WAIT→RSP_GRANTED transition.
  - No backpressure.
  - After size+1 beats, go to RSP_DONE.
- RSP_GRANTED, write channel:
  - wr_gnt_o=1 and wr_ready_o=1.
  - A beat is written to mem[addr/4 + beat] on each cycle where wr_valid_i is high. Cycles where wr_valid_i is low are stalls.
  - After size+1 accepted beats, go to RSP_DONE.
- RSP_DONE: done_o=1 for the active channel, gnt and valid low. Stay until the active req drops, then go to RSP_IDLE.
- RSP_ERROR: err_o=1 for the active channel and no memory access. Stay until req drops, then go to RSP_IDLE.
- Requester drops req while in RSP_WAIT or RSP_GRANTED: abort. Next cycle is RSP_IDLE with all outputs 0 and no further memory writes.
- A req still high on re-entry to RSP_IDLE can only be a new request, because RSP_DONE and RSP_ERROR wait for req to drop.
- Beat counter is 5 bits so it never wraps for 16 beats.

Decomposition:
- ip_codma_states_pkg gains resp_state_t, 3 bits: RSP_IDLE=000, RSP_WAIT=001, RSP_GRANTED=010, RSP_DONE=011, RSP_ERROR=100, remaining codes unused and mapped to RSP_IDLE.
- The package also gains the channel enum (CH_RD, CH_WR).
- One sub-module, ip_codma_resp_mem: single-port DEPTH×32 array with synchronous write and combinational read, so bench backdoor load and dump are possible.

Test Plan:
- LATENCY=2, preload mem[4..7]=A0..A3, read addr 0x10 size 3 -> rd_gnt_o rises 4 cycles after the req edge; four consecutive beats A0,A1,A2,A3; rd_done_o until req drops.
- Write addr 0x20 size 1, data 0xDEADBEEF, wr_valid_i low for 2 cycles, then 0xCAFEF00D -> mem[8]=DEADBEEF, mem[9]=CAFEF00D; stalls accepted; wr_done_o asserts.
- rd_req_i and wr_req_i rise on the same cycle -> write served first; read granted after write done and wr_req_i low.
- Read addr 0x12 (misaligned) -> rd_err_o, no rd_gnt_o; read addr (DEPTH-2)*4 size 3 -> rd_err_o.
- Write size 7, drop wr_req_i after 3 beats -> exactly 3 words written; RSP_IDLE next cycle.
- reset_i asserted mid read burst -> all outputs 0 the next cycle; a new request then completes normally.

Source files
------------

// File: rtl/ip_codma_states_pkg.sv
// Shared state and channel encodings for the codma responder.
// The responder's 3-bit FSM codes and the read/write channel select live here.
package ip_codma_states_pkg;

    typedef enum logic [2:0] {
        RSP_IDLE    = 3'b000,
        RSP_WAIT    = 3'b001,
        RSP_GRANTED = 3'b010,
        RSP_DONE    = 3'b011,
        RSP_ERROR   = 3'b100
    } resp_state_t;

    typedef enum logic {
        CH_RD = 1'b0,
        CH_WR = 1'b1
    } channel_t;

    localparam int RSP_BEAT_W = 5;
    localparam int RSP_LAT_W  = 4;
    localparam int RSP_DATA_W = 32;

endpackage

// File: rtl/ip_codma_resp_mem.sv
// Backing word store for the codma responder: synchronous write, combinational read.
// The array is named mem so benches can load and dump it hierarchically.
module ip_codma_resp_mem #(
    parameter int DEPTH = 1024
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   idx_i,
    input  logic [31:0]                wdata_i,
    output logic [31:0]                rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/ip_codma_bus_responder.sv
// Memory-side responder for the codma read/write request/grant protocol.
// Serves one burst at a time from an internal word memory with a programmable grant delay.
module ip_codma_bus_responder
    import ip_codma_states_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [3:0]        rd_size_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_done_o,
    output logic              rd_err_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_size_i,
    input  logic              wr_valid_i,
    input  logic [31:0]       wr_data_i,
    output logic              wr_gnt_o,
    output logic              wr_ready_o,
    output logic              wr_done_o,
    output logic              wr_err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    resp_state_t             state_q, state_d;
    channel_t                ch_q, ch_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [3:0]              size_q, size_d;
    logic [RSP_LAT_W-1:0]    lat_q, lat_d;
    logic [RSP_BEAT_W-1:0]   beat_q, beat_d;
    logic [RSP_DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                    act_req;
    logic                    req_bad;
    logic [ADDR_W:0]         span;
    logic [IDX_W-1:0]        mem_idx;
    logic                    mem_we;
    logic [31:0]             mem_rdata;

    // One extra bit keeps the end-of-burst word index from wrapping near the top of the address space.
    assign span    = ({1'b0, addr_q} >> 2) + (ADDR_W+1)'(size_q) + (ADDR_W+1)'(1);
    assign req_bad = (addr_q[1:0] != 2'b00) || (span > (ADDR_W+1)'(DEPTH));
    assign act_req = (ch_q == CH_WR) ? wr_req_i : rd_req_i;
    assign mem_idx = addr_q[IDX_W+1:2] + IDX_W'(beat_q);
    assign mem_we  = (state_q == RSP_GRANTED) && (ch_q == CH_WR) && wr_valid_i && wr_req_i;
    assign rd_data_o = rd_data_q;

    ip_codma_resp_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (mem_idx),
        .wdata_i (wr_data_i),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= RSP_IDLE;
            ch_q      <= CH_RD;
            addr_q    <= '0;
            size_q    <= '0;
            lat_q     <= '0;
            beat_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Read beats are registered, so beat_q runs one ahead of the beat on rd_data_o.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        size_d     = size_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        rd_data_d  = '0;
        rd_gnt_o   = 1'b0;
        rd_valid_o = 1'b0;
        rd_done_o  = 1'b0;
        rd_err_o   = 1'b0;
        wr_gnt_o   = 1'b0;
        wr_ready_o = 1'b0;
        wr_done_o  = 1'b0;
        wr_err_o   = 1'b0;

        case (state_q)
            RSP_IDLE: begin
                beat_d = '0;
                if (wr_req_i) begin
                    ch_d    = CH_WR;
                    addr_d  = wr_addr_i;
                    size_d  = wr_size_i;
                    lat_d   = RSP_LAT_W'(LATENCY);
                    state_d = RSP_WAIT;
                end else if (rd_req_i) begin
                    ch_d    = CH_RD;
                    addr_d  = rd_addr_i;
                    size_d  = rd_size_i;
                    lat_d   = RSP_LAT_W'(LATENCY);
                    state_d = RSP_WAIT;
                end
            end

            RSP_WAIT: begin
                if (!act_req) begin
                    state_d = RSP_IDLE;
                end else if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else if (req_bad) begin
                    state_d = RSP_ERROR;
                end else begin
                    state_d = RSP_GRANTED;
                    if (ch_q == CH_RD) begin
                        rd_data_d = mem_rdata;
                        beat_d    = 5'd1;
                    end
                end
            end

            RSP_GRANTED: begin
                if (ch_q == CH_RD) begin
                    rd_gnt_o   = 1'b1;
                    rd_valid_o = 1'b1;
                    if (!act_req) begin
                        state_d = RSP_IDLE;
                    end else if (beat_q == ({1'b0, size_q} + 5'd1)) begin
                        state_d = RSP_DONE;
                    end else begin
                        rd_data_d = mem_rdata;
                        beat_d    = beat_q + 5'd1;
                    end
                end else begin
                    wr_gnt_o   = 1'b1;
                    wr_ready_o = 1'b1;
                    if (!act_req) begin
                        state_d = RSP_IDLE;
                    end else if (wr_valid_i) begin
                        beat_d = beat_q + 5'd1;
                        if (beat_q == {1'b0, size_q}) begin
                            state_d = RSP_DONE;
                        end
                    end
                end
            end

            RSP_DONE: begin
                rd_done_o = (ch_q == CH_RD);
                wr_done_o = (ch_q == CH_WR);
                if (!act_req) begin
                    state_d = RSP_IDLE;
                end
            end

            RSP_ERROR: begin
                rd_err_o = (ch_q == CH_RD);
                wr_err_o = (ch_q == CH_WR);
                if (!act_req) begin
                    state_d = RSP_IDLE;
                end
            end

            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Directed bench for ip_codma_bus_responder: reads, stalled writes, arbitration, errors, aborts, reset.
// Expected values are hand-computed from the protocol timing with LATENCY=2.
module tb_ip_codma_bus_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int ADDR_W  = 32;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [3:0]        rd_size_i;
    logic              rd_gnt_o;
    logic              rd_valid_o;
    logic [31:0]       rd_data_o;
    logic              rd_done_o;
    logic              rd_err_o;
    logic              wr_req_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [3:0]        wr_size_i;
    logic              wr_valid_i;
    logic [31:0]       wr_data_i;
    logic              wr_gnt_o;
    logic              wr_ready_o;
    logic              wr_done_o;
    logic              wr_err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    ip_codma_bus_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_req_i   (rd_req_i),
        .rd_addr_i  (rd_addr_i),
        .rd_size_i  (rd_size_i),
        .rd_gnt_o   (rd_gnt_o),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .rd_done_o  (rd_done_o),
        .rd_err_o   (rd_err_o),
        .wr_req_i   (wr_req_i),
        .wr_addr_i  (wr_addr_i),
        .wr_size_i  (wr_size_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_gnt_o   (wr_gnt_o),
        .wr_ready_o (wr_ready_o),
        .wr_done_o  (wr_done_o),
        .wr_err_o   (wr_err_o)
    );

    function automatic logic [7:0] out_flags();
        return {rd_gnt_o, rd_valid_o, rd_done_o, rd_err_o, wr_gnt_o, wr_ready_o, wr_done_o, wr_err_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req_i   = 1'b0;
        rd_addr_i  = '0;
        rd_size_i  = '0;
        wr_req_i   = 1'b0;
        wr_addr_i  = '0;
        wr_size_i  = '0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
    endtask

    // Steps until the channel shows gnt or err; cycles is -1 if the budget runs out.
    task automatic wait_resp(input bit is_wr, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 40) begin
            step();
            cycles++;
            seen = is_wr ? (wr_gnt_o || wr_err_o) : (rd_gnt_o || rd_err_o);
        end
        if (!seen) cycles = -1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] size,
                            input logic [31:0] base, output bit ok);
        int c;
        wr_req_i   = 1'b1;
        wr_addr_i  = addr;
        wr_size_i  = size;
        wr_valid_i = 1'b1;
        wr_data_i  = base;
        wait_resp(1'b1, c);
        ok = (c > 0) && wr_gnt_o;
        if (ok) begin
            for (int i = 0; i <= int'(size); i++) begin
                wr_data_i = base + 32'(i);
                step();
            end
        end
        ok = ok && wr_done_o;
        wr_req_i   = 1'b0;
        wr_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        tests_run++;
        if (out_flags() !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000000", out_flags());
        end
        tests_run++;
        if (rd_data_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rd_data: got %h, expected 00000000", rd_data_o);
        end
    endtask

    task automatic test_preload();
        int c;
        wr_req_i   = 1'b1;
        wr_addr_i  = 32'h10;
        wr_size_i  = 4'd3;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hA0;
        wait_resp(1'b1, c);
        tests_run++;
        if (c !== LATENCY + 2) begin
            tests_failed++;
            $display("[TB] FAIL wr_gnt_latency: got %0d cycles, expected %0d", c, LATENCY + 2);
        end
        for (int i = 0; i < 4; i++) begin
            wr_data_i = 32'hA0 + 32'(i);
            step();
        end
        tests_run++;
        if ({wr_done_o, wr_gnt_o, wr_ready_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL preload_done: got done/gnt/ready %b, expected 100",
                     {wr_done_o, wr_gnt_o, wr_ready_o});
        end
        wr_req_i   = 1'b0;
        wr_valid_i = 1'b0;
        step();
        tests_run++;
        if (out_flags() !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL preload_release: got %b, expected 00000000", out_flags());
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (dut.u_mem.mem[4 + i] !== 32'hA0 + 32'(i)) begin
                tests_failed++;
                $display("[TB] FAIL preload_mem[%0d]: got %h, expected %h",
                         4 + i, dut.u_mem.mem[4 + i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_read_burst();
        int c;
        rd_req_i  = 1'b1;
        rd_addr_i = 32'h10;
        rd_size_i = 4'd3;
        wait_resp(1'b0, c);
        tests_run++;
        if (c !== LATENCY + 2) begin
            tests_failed++;
            $display("[TB] FAIL rd_gnt_latency: got %0d cycles, expected %0d", c, LATENCY + 2);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({rd_gnt_o, rd_valid_o, wr_gnt_o, rd_data_o} !== {3'b110, 32'hA0 + 32'(i)}) begin
                tests_failed++;
                $display("[TB] FAIL rd_beat%0d: got gnt/valid/wgnt %b data %h, expected 110 data %h",
                         i, {rd_gnt_o, rd_valid_o, wr_gnt_o}, rd_data_o, 32'hA0 + 32'(i));
            end
            step();
        end
        step();
        tests_run++;
        if ({rd_done_o, rd_gnt_o, rd_valid_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL rd_done_hold: got done/gnt/valid %b, expected 100",
                     {rd_done_o, rd_gnt_o, rd_valid_o});
        end
        rd_req_i = 1'b0;
        step();
        tests_run++;
        if (rd_done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rd_done_release: got %b, expected 0", rd_done_o);
        end
    endtask

    task automatic test_write_stall();
        int c;
        wr_req_i   = 1'b1;
        wr_addr_i  = 32'h20;
        wr_size_i  = 4'd1;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hDEADBEEF;
        wait_resp(1'b1, c);
        step();
        wr_valid_i = 1'b0;
        wr_data_i  = 32'h11111111;
        tests_run++;
        if ({wr_ready_o, wr_done_o} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL wr_stall_ready: got ready/done %b, expected 10", {wr_ready_o, wr_done_o});
        end
        step();
        step();
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hCAFEF00D;
        step();
        tests_run++;
        if (wr_done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wr_stall_done: got %b, expected 1", wr_done_o);
        end
        wr_req_i   = 1'b0;
        wr_valid_i = 1'b0;
        step();
        tests_run++;
        if ({dut.u_mem.mem[8], dut.u_mem.mem[9]} !== {32'hDEADBEEF, 32'hCAFEF00D}) begin
            tests_failed++;
            $display("[TB] FAIL wr_stall_mem: got %h %h, expected deadbeef cafef00d",
                     dut.u_mem.mem[8], dut.u_mem.mem[9]);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        logic [31:0] exp_rd [2];
        exp_rd[0] = 32'hDEADBEEF;
        exp_rd[1] = 32'hCAFEF00D;
        rd_req_i   = 1'b1;
        rd_addr_i  = 32'h20;
        rd_size_i  = 4'd1;
        wr_req_i   = 1'b1;
        wr_addr_i  = 32'h30;
        wr_size_i  = 4'd0;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'h12345678;
        wait_resp(1'b1, c);
        tests_run++;
        if ({wr_gnt_o, rd_gnt_o} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL both_req_wr_first: got wgnt/rgnt %b, expected 10", {wr_gnt_o, rd_gnt_o});
        end
        step();
        tests_run++;
        if ({wr_done_o, rd_gnt_o, rd_done_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL both_req_wr_done: got wdone/rgnt/rdone %b, expected 100",
                     {wr_done_o, rd_gnt_o, rd_done_o});
        end
        wr_req_i   = 1'b0;
        wr_valid_i = 1'b0;
        wait_resp(1'b0, c);
        tests_run++;
        if (c !== LATENCY + 3) begin
            tests_failed++;
            $display("[TB] FAIL both_req_rd_latency: got %0d cycles, expected %0d", c, LATENCY + 3);
        end
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({rd_valid_o, rd_data_o} !== {1'b1, exp_rd[i]}) begin
                tests_failed++;
                $display("[TB] FAIL both_req_rd_beat%0d: got valid %b data %h, expected 1 %h",
                         i, rd_valid_o, rd_data_o, exp_rd[i]);
            end
            step();
        end
        rd_req_i = 1'b0;
        step();
        tests_run++;
        if (dut.u_mem.mem[12] !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL both_req_wr_mem: got %h, expected 12345678", dut.u_mem.mem[12]);
        end
    endtask

    task automatic test_errors();
        int c;
        rd_req_i  = 1'b1;
        rd_addr_i = 32'h12;
        rd_size_i = 4'd0;
        wait_resp(1'b0, c);
        step();
        tests_run++;
        if ({rd_err_o, rd_gnt_o, wr_err_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL rd_misaligned: got err/gnt/werr %b, expected 100", {rd_err_o, rd_gnt_o, wr_err_o});
        end
        rd_req_i = 1'b0;
        step();
        tests_run++;
        if (rd_err_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rd_err_release: got %b, expected 0", rd_err_o);
        end

        rd_req_i  = 1'b1;
        rd_addr_i = 32'((DEPTH - 2) * 4);
        rd_size_i = 4'd3;
        wait_resp(1'b0, c);
        tests_run++;
        if ({rd_err_o, rd_gnt_o} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL rd_out_of_range: got err/gnt %b, expected 10", {rd_err_o, rd_gnt_o});
        end
        rd_req_i = 1'b0;
        step();

        rd_req_i  = 1'b1;
        rd_addr_i = 32'((DEPTH - 4) * 4);
        rd_size_i = 4'd3;
        wait_resp(1'b0, c);
        tests_run++;
        if ({rd_err_o, rd_gnt_o} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL rd_exact_fit: got err/gnt %b, expected 01", {rd_err_o, rd_gnt_o});
        end
        rd_req_i = 1'b0;
        step();
        tests_run++;
        if (out_flags() !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rd_abort: got %b, expected 00000000", out_flags());
        end

        wr_req_i   = 1'b1;
        wr_addr_i  = 32'h21;
        wr_size_i  = 4'd0;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hBAD0BAD0;
        wait_resp(1'b1, c);
        tests_run++;
        if ({wr_err_o, wr_gnt_o, rd_err_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL wr_misaligned: got err/gnt/rerr %b, expected 100", {wr_err_o, wr_gnt_o, rd_err_o});
        end
        wr_req_i   = 1'b0;
        wr_valid_i = 1'b0;
        step();
    endtask

    task automatic test_write_abort();
        int c;
        bit ok;
        logic [31:0] exp;
        do_write(32'h100, 4'd7, 32'h0, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_prefill: got completion %b, expected 1", ok);
        end
        wr_req_i   = 1'b1;
        wr_addr_i  = 32'h100;
        wr_size_i  = 4'd7;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'h50000000;
        wait_resp(1'b1, c);
        for (int i = 0; i < 3; i++) begin
            wr_data_i = 32'h50000000 + 32'(i);
            step();
        end
        wr_data_i = 32'h50000003;
        wr_req_i  = 1'b0;
        step();
        tests_run++;
        if (out_flags() !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL wr_abort_idle: got %b, expected 00000000", out_flags());
        end
        step();
        wr_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 3) ? 32'h50000000 + 32'(i) : 32'(i);
            tests_run++;
            if (dut.u_mem.mem[64 + i] !== exp) begin
                tests_failed++;
                $display("[TB] FAIL wr_abort_mem[%0d]: got %h, expected %h", 64 + i, dut.u_mem.mem[64 + i], exp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int c;
        rd_req_i  = 1'b1;
        rd_addr_i = 32'h10;
        rd_size_i = 4'd3;
        wait_resp(1'b0, c);
        step();
        reset_i = 1'b1;
        step();
        tests_run++;
        if ({out_flags(), rd_data_o} !== 40'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_burst: got flags %b data %h, expected all zero", out_flags(), rd_data_o);
        end
        reset_i  = 1'b0;
        rd_req_i = 1'b0;
        step();
        rd_req_i = 1'b1;
        wait_resp(1'b0, c);
        tests_run++;
        if (c !== LATENCY + 2) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_latency: got %0d cycles, expected %0d", c, LATENCY + 2);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({rd_valid_o, rd_data_o} !== {1'b1, 32'hA0 + 32'(i)}) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_beat%0d: got valid %b data %h, expected 1 %h",
                         i, rd_valid_o, rd_data_o, 32'hA0 + 32'(i));
            end
            step();
        end
        tests_run++;
        if (rd_done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_done: got %b, expected 1", rd_done_o);
        end
        rd_req_i = 1'b0;
        step();
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        test_reset();
        test_preload();
        test_read_burst();
        test_write_stall();
        test_simultaneous();
        test_errors();
        test_write_abort();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
